// File: rtl/uart2wifi_core_uart_rx.sv
// UART receive front end: 2-flop synchronizer, oversampled 8N1 deframer and a small
// receive FIFO with a valid/ready handshake toward the command/register path.
module uart2wifi_core_uart_rx #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        baudtick,
    input  logic                        rx_in,
    output logic [DATA_BITS-1:0]        rx_data,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        frame_err,
    output logic                        overrun,
    output logic                        busy
);

    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned TickW = $clog2(OVERSAMPLE);
    localparam int unsigned BitW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TickW-1:0] TickMid  = TickW'(OVERSAMPLE / 2 - 1);
    localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);
    localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_BITS - 1);
    localparam logic [CntW-1:0]  CntFull  = CntW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    // Synchronizer
    logic sync1_q;
    logic sync2_q;
    logic rx_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx_in;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s = sync2_q;

    // Deframer state
    state_e               state_q, state_d;
    logic [TickW-1:0]     tick_cnt_q, tick_cnt_d;
    logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;

    // FIFO state
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]      wr_ptr_q;
    logic [PtrW-1:0]      rd_ptr_q;
    logic [CntW-1:0]      count_q;
    logic                 push;
    logic                 pop;
    logic                 full;

    assign rx_valid   = (count_q != '0);
    assign full       = (count_q == CntFull);
    assign pop        = rx_valid & rx_ready;
    assign rx_data    = mem_q[rd_ptr_q];
    assign fifo_count = count_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != StIdle);

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        push        = 1'b0;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        if (baudtick) begin
            unique case (state_q)
                StIdle: begin
                    if (!rx_s) begin
                        state_d    = StStart;
                        tick_cnt_d = '0;
                    end
                end
                StStart: begin
                    // Half a bit in: still low means a real start bit, else a glitch.
                    if (tick_cnt_q == TickMid) begin
                        if (!rx_s) begin
                            state_d    = StData;
                            tick_cnt_d = '0;
                            bit_cnt_d  = '0;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                StData: begin
                    if (tick_cnt_q == TickLast) begin
                        shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
                        tick_cnt_d = '0;
                        if (bit_cnt_q == BitLast) begin
                            state_d = StStop;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                StStop: begin
                    if (tick_cnt_q == TickLast) begin
                        state_d    = StIdle;
                        tick_cnt_d = '0;
                        // A simultaneous pop frees a slot, so a full FIFO still accepts.
                        if (!rx_s) begin
                            frame_err_d = 1'b1;
                        end else if (full && !pop) begin
                            overrun_d = 1'b1;
                        end else begin
                            push = 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= shift_q;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_uart2wifi_core_uart_rx.sv
// Directed bench for uart2wifi_core_uart_rx: 8N1 frames at 16 ticks/bit, tick every 10 clk.
module tb_uart2wifi_core_uart_rx;

    localparam int unsigned BitClk = 160;

    logic       clk;
    logic       rst;
    logic       baudtick;
    logic       rx_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [2:0] fifo_count;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_pass;
    int n_checks;
    int fe_cnt;
    int ov_cnt;
    bit busy_seen;
    logic [7:0] hs_q[$];

    uart2wifi_core_uart_rx #(
        .OVERSAMPLE(16),
        .DATA_BITS (8),
        .FIFO_DEPTH(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .baudtick  (baudtick),
        .rx_in     (rx_in),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .fifo_count(fifo_count),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        int div;
        div = 0;
        baudtick = 1'b0;
        forever begin
            @(negedge clk);
            baudtick = (div == 9);
            div = (div == 9) ? 0 : div + 1;
        end
    end

    // Observe just after the stimulus edge; these are the values the next posedge uses.
    always @(negedge clk) begin
        #1;
        if (frame_err === 1'b1) fe_cnt++;
        if (overrun === 1'b1) ov_cnt++;
        if (busy === 1'b1) busy_seen = 1'b1;
        if (rx_valid === 1'b1 && rx_ready === 1'b1) hs_q.push_back(rx_data);
    end

    task automatic clear_obs();
        fe_cnt = 0;
        ov_cnt = 0;
        busy_seen = 1'b0;
        hs_q.delete();
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx_in = 1'b0;
        repeat (BitClk) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            repeat (BitClk) @(negedge clk);
        end
        rx_in = stop;
        repeat (BitClk) @(negedge clk);
        rx_in = 1'b1;
    endtask

    task automatic drain(input int cycles);
        rx_ready = 1'b1;
        repeat (cycles) @(negedge clk);
        rx_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        if (rx_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", rx_valid);
        else n_pass++;
        n_checks++;
        if (rx_data !== 8'h00) $display("FAIL reset_data: got %h expected 00", rx_data);
        else n_pass++;
        n_checks++;
        if (fifo_count !== 3'd0) $display("FAIL reset_count: got %0d expected 0", fifo_count);
        else n_pass++;
        n_checks++;
        if (frame_err !== 1'b0 || overrun !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_flags: got fe=%b ov=%b busy=%b expected 0 0 0",
                     frame_err, overrun, busy);
        else n_pass++;
        n_checks++;
        repeat (50) @(negedge clk);
        if (busy_seen !== 1'b0) $display("FAIL reset_idle_busy: got %b expected 0", busy_seen);
        else n_pass++;
        n_checks++;
    endtask

    task automatic test_single_byte();
        clear_obs();
        send_frame(8'hA5, 1'b1);
        repeat (20) @(negedge clk);
        if (rx_valid !== 1'b1) $display("FAIL single_valid: got %b expected 1", rx_valid);
        else n_pass++;
        n_checks++;
        if (rx_data !== 8'hA5) $display("FAIL single_data: got %h expected a5", rx_data);
        else n_pass++;
        n_checks++;
        if (fifo_count !== 3'd1) $display("FAIL single_count: got %0d expected 1", fifo_count);
        else n_pass++;
        n_checks++;
        if (fe_cnt !== 0 || ov_cnt !== 0)
            $display("FAIL single_errs: got fe=%0d ov=%0d expected 0 0", fe_cnt, ov_cnt);
        else n_pass++;
        n_checks++;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        #1;
        if (rx_valid !== 1'b0 || fifo_count !== 3'd0)
            $display("FAIL single_pop: got valid=%b count=%0d expected 0 0", rx_valid, fifo_count);
        else n_pass++;
        n_checks++;
        if (hs_q.size() !== 1) $display("FAIL single_hs: got %0d expected 1", hs_q.size());
        else n_pass++;
        n_checks++;
    endtask

    task automatic test_back_to_back();
        clear_obs();
        rx_ready = 1'b1;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        repeat (200) @(negedge clk);
        rx_ready = 1'b0;
        if (hs_q.size() !== 2) $display("FAIL b2b_hs: got %0d expected 2", hs_q.size());
        else n_pass++;
        n_checks++;
        if (hs_q[0] !== 8'h00 || hs_q[1] !== 8'hFF)
            $display("FAIL b2b_data: got %h %h expected 00 ff", hs_q[0], hs_q[1]);
        else n_pass++;
        n_checks++;
        if (fe_cnt !== 0 || ov_cnt !== 0)
            $display("FAIL b2b_errs: got fe=%0d ov=%0d expected 0 0", fe_cnt, ov_cnt);
        else n_pass++;
        n_checks++;
    endtask

    task automatic test_glitch();
        clear_obs();
        rx_in = 1'b0;
        repeat (30) @(negedge clk);
        rx_in = 1'b1;
        repeat (200) @(negedge clk);
        if (busy_seen !== 1'b1 || busy !== 1'b0)
            $display("FAIL glitch_busy: got seen=%b now=%b expected 1 0", busy_seen, busy);
        else n_pass++;
        n_checks++;
        if (fifo_count !== 3'd0 || fe_cnt !== 0 || ov_cnt !== 0)
            $display("FAIL glitch_quiet: got count=%0d fe=%0d ov=%0d expected 0 0 0",
                     fifo_count, fe_cnt, ov_cnt);
        else n_pass++;
        n_checks++;
        send_frame(8'h5A, 1'b1);
        repeat (20) @(negedge clk);
        if (rx_data !== 8'h5A || fifo_count !== 3'd1)
            $display("FAIL glitch_next: got data=%h count=%0d expected 5a 1", rx_data, fifo_count);
        else n_pass++;
        n_checks++;
        drain(3);
    endtask

    task automatic test_frame_err();
        clear_obs();
        send_frame(8'h3C, 1'b0);
        repeat (200) @(negedge clk);
        if (fe_cnt !== 1) $display("FAIL ferr_pulse: got %0d cycles expected 1", fe_cnt);
        else n_pass++;
        n_checks++;
        if (fifo_count !== 3'd0 || rx_valid !== 1'b0 || ov_cnt !== 0)
            $display("FAIL ferr_nopush: got count=%0d valid=%b ov=%0d expected 0 0 0",
                     fifo_count, rx_valid, ov_cnt);
        else n_pass++;
        n_checks++;
    endtask

    task automatic test_overrun();
        clear_obs();
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
        if (ov_cnt !== 0) $display("FAIL ovr_early: got %0d expected 0", ov_cnt);
        else n_pass++;
        n_checks++;
        send_frame(8'h05, 1'b1);
        repeat (20) @(negedge clk);
        if (fifo_count !== 3'd4) $display("FAIL ovr_count: got %0d expected 4", fifo_count);
        else n_pass++;
        n_checks++;
        if (ov_cnt !== 1 || fe_cnt !== 0)
            $display("FAIL ovr_pulse: got ov=%0d fe=%0d expected 1 0", ov_cnt, fe_cnt);
        else n_pass++;
        n_checks++;
        drain(10);
        if (hs_q.size() !== 4 || hs_q[0] !== 8'h01 || hs_q[1] !== 8'h02 ||
            hs_q[2] !== 8'h03 || hs_q[3] !== 8'h04)
            $display("FAIL ovr_order: got n=%0d %h %h %h %h expected 4 01 02 03 04",
                     hs_q.size(), hs_q[0], hs_q[1], hs_q[2], hs_q[3]);
        else n_pass++;
        n_checks++;
    endtask

    task automatic test_reset_mid_frame();
        clear_obs();
        send_frame(8'h66, 1'b1);
        repeat (20) @(negedge clk);
        // Start bit plus three data bits of 0x77, then reset.
        rx_in = 1'b0;
        repeat (BitClk) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx_in = 1'b1;
            repeat (BitClk) @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rx_in = 1'b1;
        #1;
        if (rx_valid !== 1'b0 || rx_data !== 8'h00 || fifo_count !== 3'd0)
            $display("FAIL rstmid_fifo: got valid=%b data=%h count=%0d expected 0 00 0",
                     rx_valid, rx_data, fifo_count);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0)
            $display("FAIL rstmid_flags: got busy=%b fe=%b ov=%b expected 0 0 0",
                     busy, frame_err, overrun);
        else n_pass++;
        n_checks++;
        repeat (1800) @(negedge clk);
        if (fifo_count !== 3'd0 || fe_cnt !== 0 || ov_cnt !== 0 || busy !== 1'b0)
            $display("FAIL rstmid_after: got count=%0d fe=%0d ov=%0d busy=%b expected 0 0 0 0",
                     fifo_count, fe_cnt, ov_cnt, busy);
        else n_pass++;
        n_checks++;
    endtask

    task automatic test_full_push_pop();
        bit found;
        clear_obs();
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        send_frame(8'h33, 1'b1);
        send_frame(8'h44, 1'b1);
        repeat (100) @(negedge clk);
        found = 1'b0;
        fork
            send_frame(8'h55, 1'b1);
            begin
                for (int i = 0; i < 2000 && !found; i++) begin
                    @(negedge clk);
                    if (busy === 1'b1) found = 1'b1;
                end
                if (found) begin
                    // Stop-sample tick lands 1520 clk after the detect tick.
                    repeat (1519) @(negedge clk);
                    rx_ready = 1'b1;
                    @(negedge clk);
                    rx_ready = 1'b0;
                end
            end
        join
        if (!found) $display("FAIL fullpp_start: got busy=0 expected 1 within 2000 cycles");
        else n_pass++;
        n_checks++;
        repeat (20) @(negedge clk);
        if (ov_cnt !== 0) $display("FAIL fullpp_overrun: got %0d expected 0", ov_cnt);
        else n_pass++;
        n_checks++;
        if (fifo_count !== 3'd4) $display("FAIL fullpp_count: got %0d expected 4", fifo_count);
        else n_pass++;
        n_checks++;
        drain(10);
        if (hs_q.size() !== 5 || hs_q[0] !== 8'h11 || hs_q[1] !== 8'h22 ||
            hs_q[2] !== 8'h33 || hs_q[3] !== 8'h44 || hs_q[4] !== 8'h55)
            $display("FAIL fullpp_order: got n=%0d %h %h %h %h %h expected 5 11 22 33 44 55",
                     hs_q.size(), hs_q[0], hs_q[1], hs_q[2], hs_q[3], hs_q[4]);
        else n_pass++;
        n_checks++;
    endtask

    initial begin
        n_pass = 0;
        n_checks = 0;
        rst = 1'b1;
        rx_in = 1'b1;
        rx_ready = 1'b0;
        clear_obs();
        @(negedge clk);
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_reset_mid_frame();
        test_full_push_pop();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart2wifi_core_uart_rx.md
# uart2wifi_core_uart_rx

UART receive front end of the uart2wifi core. It samples the asynchronous serial input using the 16x oversampling tick from `uart2wifi_core_baudrategen` and deframes 8N1 characters. Received bytes are buffered in a small FIFO and handed downstream over a valid/ready handshake. The consumer is the core's command/register path, which writes into `uart2wifi_core_sram`.

## Interface
- `OVERSAMPLE`, default 16: baud ticks per bit period. Must be even and at least 4.
- `DATA_BITS`, default 8: data bits per frame, sent LSB first.
- `FIFO_DEPTH`, default 4: receive buffer entries. Must be a power of 2 and at least 2.

- `clk`, in, 1: single clock. Everything is synchronous to it.
- `rst`, in, 1: synchronous, active-high reset.
- `baudtick`, in, 1: one-`clk` pulse at OVERSAMPLE × baud rate.
- `rx_in`, in, 1: asynchronous serial line, idle high.
- `rx_data`, out, DATA_BITS: byte at the FIFO head.
- `rx_valid`, out, 1: FIFO is non-empty.
- `rx_ready`, in, 1: consumer accepts the head byte this cycle.
- `fifo_count`, out, $clog2(FIFO_DEPTH)+1: number of occupied entries.
- `frame_err`, out, 1: one-cycle pulse when a stop bit is sampled low.
- `overrun`, out, 1: one-cycle pulse when a good byte is dropped because the FIFO is full.
- `busy`, out, 1: high whenever the FSM is not in IDLE.

## Operation
- **Synchronizer.** `rx_in` passes through a 2-flop synchronizer to produce `rx_s`. Both flops reset to 1.
- **FSM counters.** States are IDLE, START, DATA, STOP. `tick_cnt` and `bit_cnt` advance only on `clk` edges where `baudtick`=1.
- **IDLE.** On a tick with `rx_s`=0, go to START and set `tick_cnt`=0.
- **START.** On a tick, if `tick_cnt`==OVERSAMPLE/2-1:
  - if `rx_s`=0, go to DATA with `tick_cnt`=0 and `bit_cnt`=0;
  - if `rx_s`=1, treat it as a glitch and return to IDLE with nothing reported.
  - Otherwise increment `tick_cnt`.
- **DATA.** On a tick with `tick_cnt`==OVERSAMPLE-1:
  - shift `rx_s` into the MSB of the shift register (shift right), then set `tick_cnt`=0;
  - if `bit_cnt`==DATA_BITS-1, go to STOP; otherwise increment `bit_cnt`.
- **STOP.** On a tick with `tick_cnt`==OVERSAMPLE-1:
  - if `rx_s`=1 and the FIFO has room, or a pop happens this same cycle, push the shift register;
  - if `rx_s`=1 and the FIFO is full with no pop, drop the byte and pulse `overrun`;
  - if `rx_s`=0, drop the byte and pulse `frame_err`;
  - in all three cases, go to IDLE.
- **Sampling point.** Each bit is sampled mid-bit, OVERSAMPLE ticks after the previous sample.
- **FIFO.** It is a circular buffer with a wrapping write pointer and read pointer.
  - A pop happens when `rx_valid`=1 and `rx_ready`=1.
  - A push and a pop in the same cycle leave `fifo_count` unchanged. This includes the full case, which is not an overrun.
  - `rx_ready` asserted while the FIFO is empty is ignored.
- **Output stability.** `rx_data` and `rx_valid` stay stable while `rx_valid`=1 and `rx_ready`=0.
- **Reset.** Reset in any state forces IDLE and clears both counters, both pointers and the shift register. It also zeroes the FIFO storage; any partial frame is discarded.

## Timing
- Reset values:
  - `rx_valid`=0, `rx_data`=0, `fifo_count`=0;
  - `frame_err`=0, `overrun`=0, `busy`=0;
  - synchronizer flops = 1.
- Input latency: a change on `rx_in` is visible on `rx_s` 2 `clk` cycles later.
- Output latency: the push happens on the `clk` edge carrying the stop-sample tick. `rx_valid` rises and `fifo_count` increments in the next cycle. `frame_err` and `overrun` are high for exactly that one following cycle.
- Pop latency: `rx_data` shows the next entry, and `fifo_count` decrements, the cycle after the handshake.
- `busy` rises the cycle after the start-detect tick. It falls the cycle after the stop-sample tick or the glitch-reject tick.
- Frame length: detect to stop sample is OVERSAMPLE/2 + (DATA_BITS+1)·OVERSAMPLE ticks, which is 152 ticks at the defaults.
- A new start bit can be detected on the first tick after returning to IDLE, so back-to-back frames need no idle gap.
- Pointers wrap modulo FIFO_DEPTH. `fifo_count` saturates at neither end because push and pop are both gated.

## Test plan
- **Single byte.** Pulse `baudtick` every 10 clk. Drive 0xA5 as 8N1 with 16 ticks per bit, holding `rx_ready`=0. Expect `rx_valid`=1, `rx_data`=0xA5 and `fifo_count`=1, with no `frame_err` or `overrun`. Then assert `rx_ready` for 1 cycle and expect `rx_valid`=0.
- **Back-to-back frames.** Send 0x00 then 0xFF with no idle gap, with `rx_ready`=1 throughout. Expect exactly two handshakes, carrying 0x00 then 0xFF.
- **Glitch rejection.** Drive `rx_in` low for 3 ticks, then high. Expect `busy` to go 1 then back to 0, with no push and no error pulse. A following 0x5A frame must then be received correctly.
- **Framing error.** Send 0x3C with the stop bit driven low. Expect a single 1-cycle `frame_err` pulse, `fifo_count`=0 and `rx_valid`=0.
- **Overrun and ordering.** With `rx_ready`=0, send 0x01 through 0x05. Expect `fifo_count`=4 and a single `overrun` pulse on byte 5. Then assert `rx_ready`=1 and expect the readout order 0x01, 0x02, 0x03, 0x04.
- **Reset mid-frame and full-FIFO push/pop.**
  - Assert `rst` for 1 cycle during the DATA bits of 0x77. Expect all outputs at their reset values and no byte delivered.
  - Separately, fill the FIFO to 4 entries and pop in the same cycle as the stop sample of a 5th byte. Expect no `overrun`, with `fifo_count` staying at 4.
